// File: rtl/keyboard_tone_pkg.sv
// keyboard_tone_pkg: shared modes, default divider table, tone states and index helper
package keyboard_tone_pkg;

    localparam int MODE_PRIORITY = 0;
    localparam int MODE_LAST     = 1;
    localparam int CLK_HZ        = 25_000_000;

    // Half-period lengths at CLK_HZ; key 0 sits in the lowest slice (DO)
    localparam logic [63:0] DEFAULT_DIV_TABLE = {16'd17906, 16'd18977, 16'd21302, 16'd23860};

    typedef enum logic {IDLE, RUN} tone_state_e;

    // Lowest set bit index of a key vector (0 when empty)
    function automatic logic [3:0] lowest_idx(input logic [15:0] v);
        logic [3:0] r;
        r = '0;
        for (int i = 15; i >= 0; i--) if (v[i]) r = 4'(i);
        return r;
    endfunction

endpackage

// File: rtl/keyboard_tone_gen_key_debounce.sv
// key_debounce: 2-flop synchroniser and debounce counter for one active-low key
//   clk, reset : clock, synchronous active-high reset
//   key_n      : raw asynchronous key, active-low
//   key_db     : debounced key, active-high
module key_debounce
    import keyboard_tone_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 25000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic key_db
);

    localparam int CW = DEBOUNCE_CYC > 1 ? $clog2(DEBOUNCE_CYC) : 1;

    logic          s1_q, s2_q, db_q, db_d, hit;
    logic [CW-1:0] cnt_q, cnt_d;

    assign hit    = cnt_q == CW'(DEBOUNCE_CYC - 1);
    assign cnt_d  = (s2_q == db_q || hit) ? '0 : cnt_q + 1'b1;
    assign db_d   = (s2_q != db_q && hit) ? ~db_q : db_q;
    assign key_db = db_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            db_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            s1_q  <= ~key_n;
            s2_q  <= s1_q;
            db_q  <= db_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/keyboard_tone_gen.sv
// keyboard_tone_gen: N-key debounced tone generator with phase-coherent note changes
//   clk, reset : clock, synchronous active-high reset
//   keys_n     : raw keys, active-low, asynchronous
//   pwm_out    : square-wave audio output
//   note_valid : a note is sounding
//   note_idx   : index of the sounding key, 0 when silent
//   keys_db    : debounced key state, active-high
module keyboard_tone_gen
    import keyboard_tone_pkg::*;
#(
    parameter int                      N_KEYS       = 4,
    parameter int                      DIV_W        = 16,
    parameter logic [N_KEYS*DIV_W-1:0] DIV_TABLE    = DEFAULT_DIV_TABLE,
    parameter int                      DEBOUNCE_CYC = 25000,
    parameter int                      MODE         = MODE_PRIORITY,
    localparam int                     IW           = N_KEYS > 1 ? $clog2(N_KEYS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_KEYS-1:0] keys_n,
    output logic              pwm_out,
    output logic              note_valid,
    output logic [IW-1:0]     note_idx,
    output logic [N_KEYS-1:0] keys_db
);

    logic [N_KEYS-1:0] prev_q, rise;
    logic [IW-1:0]     sel_q, sel_d, cur_q, cur_d, low_db, low_rise;
    logic              sel_valid_q;
    tone_state_e       state_q, state_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d, div_q, div_d, sel_div;
    logic              pwm_q, pwm_d, wrap;

    genvar k;
    generate
        for (k = 0; k < N_KEYS; k++) begin : g_key
            key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
                .clk   (clk),
                .reset (reset),
                .key_n (keys_n[k]),
                .key_db(keys_db[k])
            );
        end
    endgenerate

    assign rise     = keys_db & ~prev_q;
    assign low_db   = IW'(lowest_idx(16'(keys_db)));
    assign low_rise = IW'(lowest_idx(16'(rise)));
    // Last-pressed: newest rise wins, keep sel while held, else fall back to lowest held
    assign sel_d    = (MODE == MODE_LAST) ? ((|rise) ? low_rise : keys_db[sel_q] ? sel_q : low_db) : low_db;
    assign sel_div  = DIV_TABLE[sel_q*DIV_W +: DIV_W];
    assign wrap     = cnt_q == div_q - 1'b1;

    // A new sel only takes effect at a half-period boundary; silence is never deferred
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        cur_d   = cur_q;
        pwm_d   = pwm_q;
        if (!sel_valid_q) begin
            state_d = IDLE;
            cnt_d   = '0;
            pwm_d   = 1'b0;
        end else if (state_q == IDLE || wrap) begin
            state_d = RUN;
            cnt_d   = '0;
            div_d   = sel_div;
            cur_d   = sel_q;
            pwm_d   = (state_q == IDLE) ? 1'b1 : ~pwm_q;
        end else begin
            cnt_d   = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q      <= '0;
            sel_q       <= '0;
            sel_valid_q <= 1'b0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            div_q       <= '0;
            cur_q       <= '0;
            pwm_q       <= 1'b0;
        end else begin
            prev_q      <= keys_db;
            sel_q       <= sel_d;
            sel_valid_q <= |keys_db;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            div_q       <= div_d;
            cur_q       <= cur_d;
            pwm_q       <= pwm_d;
        end
    end

    // Gating with sel_valid mutes the output in the same cycle the selection empties
    assign pwm_out    = pwm_q & sel_valid_q;
    assign note_valid = state_q == RUN;
    assign note_idx   = (state_q == RUN) ? cur_q : '0;

endmodule

// File: tb/tb_keyboard_tone_gen.sv
// tb_keyboard_tone_gen: scoreboard bench for keyboard_tone_gen in priority, last-pressed and 8-key setups
module tb_keyboard_tone_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] kn_a, kn_b;
    logic [7:0] kn_c;
    logic       pwm_a, nv_a, pwm_b, nv_b, pwm_c, nv_c;
    logic [1:0] idx_a, idx_b;
    logic [2:0] idx_c;
    logic [3:0] db_a, db_b;
    logic [7:0] db_c;

    int   errors = 0;
    int   checks = 0;
    int   mon = 0;
    int   exp_q[$];
    logic       pwm_m;
    logic [7:0] db_m;

    always #5 clk = ~clk;

    keyboard_tone_gen #(.N_KEYS(4), .DIV_W(16), .DIV_TABLE({16'd30, 16'd40, 16'd50, 16'd60}),
        .DEBOUNCE_CYC(16), .MODE(0)) u_a (
        .clk(clk), .reset(reset), .keys_n(kn_a), .pwm_out(pwm_a),
        .note_valid(nv_a), .note_idx(idx_a), .keys_db(db_a));

    keyboard_tone_gen #(.N_KEYS(4), .DIV_W(16), .DIV_TABLE({16'd30, 16'd40, 16'd50, 16'd60}),
        .DEBOUNCE_CYC(16), .MODE(1)) u_b (
        .clk(clk), .reset(reset), .keys_n(kn_b), .pwm_out(pwm_b),
        .note_valid(nv_b), .note_idx(idx_b), .keys_db(db_b));

    keyboard_tone_gen #(.N_KEYS(8), .DIV_W(8),
        .DIV_TABLE({8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2}),
        .DEBOUNCE_CYC(16), .MODE(0)) u_c (
        .clk(clk), .reset(reset), .keys_n(kn_c), .pwm_out(pwm_c),
        .note_valid(nv_c), .note_idx(idx_c), .keys_db(db_c));

    assign pwm_m = (mon == 2) ? pwm_c : (mon == 1) ? pwm_b : pwm_a;
    assign db_m  = (mon == 2) ? db_c : (mon == 1) ? {4'b0, db_b} : {4'b0, db_a};

    function automatic int div_ab(input int k);
        return 60 - 10 * k;
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Cycles until the monitored keys_db equals target (200 on timeout)
    task automatic wait_db(input logic [7:0] target, output int n);
        n = 0;
        while (db_m !== target && n < 200) begin
            cyc(1);
            n++;
        end
    endtask

    // Cycles until the monitored pwm leaves its current level (1000 on timeout)
    task automatic measure(output int len, output logic lvl);
        lvl = pwm_m;
        len = 0;
        while (pwm_m === lvl && len < 1000) begin
            cyc(1);
            len++;
        end
    endtask

    task automatic test_reset();
        int bad;
        reset = 1'b1;
        kn_a = '1;
        kn_b = '1;
        kn_c = '1;
        cyc(3);
        checks++;
        if ({pwm_a, nv_a, idx_a, db_a, pwm_b, nv_b, idx_b, db_b} !== '0) begin
            errors++;
            $display("FAIL reset_ab: got %b expected 0", {pwm_a, nv_a, idx_a, db_a, pwm_b, nv_b, idx_b, db_b});
        end
        checks++;
        if ({pwm_c, nv_c, idx_c, db_c} !== '0) begin
            errors++;
            $display("FAIL reset_c: got %b expected 0", {pwm_c, nv_c, idx_c, db_c});
        end
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 400; i++) begin
            cyc(1);
            if ({pwm_a, nv_a, db_a, pwm_b, nv_b, db_b, pwm_c, nv_c, db_c} !== '0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL idle_quiet: got %0d active cycles expected 0", bad);
        end
    endtask

    task automatic test_single_keys();
        int n, len, e;
        logic lvl;
        mon = 0;
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(div_ab(k));
            exp_q.push_back(div_ab(k));
            kn_a = ~(4'b1 << k);
            wait_db(8'(1 << k), n);
            checks++;
            if (n !== 18) begin
                errors++;
                $display("FAIL press_latency_k%0d: got %0d expected 18", k, n);
            end
            checks++;
            if (db_a !== 4'(1 << k)) begin
                errors++;
                $display("FAIL keys_db_k%0d: got %b expected %b", k, db_a, 4'(1 << k));
            end
            cyc(1);
            measure(len, lvl);
            for (int p = 0; p < 2; p++) begin
                measure(len, lvl);
                e = exp_q.pop_front();
                checks++;
                if (len !== e || lvl !== (p == 0)) begin
                    errors++;
                    $display("FAIL phase_k%0d_%0d: got len %0d lvl %b expected len %0d lvl %b", k, p, len, lvl, e, p == 0);
                end
            end
            checks++;
            if (nv_a !== 1'b1 || idx_a !== 2'(k)) begin
                errors++;
                $display("FAIL note_k%0d: got valid %b idx %0d expected 1 %0d", k, nv_a, idx_a, k);
            end
            kn_a = '1;
            wait_db(8'h00, n);
            cyc(3);
        end
    endtask

    task automatic test_priority();
        int n, len, e;
        logic lvl;
        mon = 0;
        exp_q.push_back(60);
        exp_q.push_back(60);
        kn_a = '0;
        wait_db(8'h0f, n);
        cyc(1);
        measure(len, lvl);
        for (int p = 0; p < 2; p++) begin
            measure(len, lvl);
            e = exp_q.pop_front();
            checks++;
            if (len !== e) begin
                errors++;
                $display("FAIL prio_all_%0d: got %0d expected %0d", p, len, e);
            end
        end
        checks++;
        if (idx_a !== 2'd0) begin
            errors++;
            $display("FAIL prio_idx0: got %0d expected 0", idx_a);
        end
        cyc(5);
        kn_a[0] = 1'b1;
        measure(len, lvl);
        checks++;
        if (len + 5 !== 60 || lvl !== 1'b1) begin
            errors++;
            $display("FAIL prio_deferred: got len %0d lvl %b expected 60 1", len + 5, lvl);
        end
        exp_q.push_back(50);
        exp_q.push_back(50);
        for (int p = 0; p < 2; p++) begin
            measure(len, lvl);
            e = exp_q.pop_front();
            checks++;
            if (len !== e) begin
                errors++;
                $display("FAIL prio_new_%0d: got %0d expected %0d", p, len, e);
            end
        end
        checks++;
        if (idx_a !== 2'd1) begin
            errors++;
            $display("FAIL prio_idx1: got %0d expected 1", idx_a);
        end
        kn_a = '1;
        wait_db(8'h00, n);
        cyc(3);
    endtask

    task automatic test_last_pressed();
        logic [3:0] kns [6];
        int         idxs[6];
        int         n, len, e;
        logic       lvl;
        kns  = '{4'b1011, 4'b1001, 4'b1011, 4'b0011, 4'b1111, 4'b0101};
        idxs = '{2, 1, 2, 3, -1, 1};
        mon = 1;
        for (int i = 0; i < 6; i++) begin
            kn_b = kns[i];
            wait_db({4'b0, ~kns[i]}, n);
            checks++;
            if (n !== 18) begin
                errors++;
                $display("FAIL last_db_step%0d: got %0d cycles expected 18", i, n);
            end
            if (idxs[i] >= 0) begin
                exp_q.push_back(div_ab(idxs[i]));
                exp_q.push_back(div_ab(idxs[i]));
                cyc(1);
                measure(len, lvl);
                for (int p = 0; p < 2; p++) begin
                    measure(len, lvl);
                    e = exp_q.pop_front();
                    checks++;
                    if (len !== e) begin
                        errors++;
                        $display("FAIL last_step%0d_%0d: got %0d expected %0d", i, p, len, e);
                    end
                end
                checks++;
                if (idx_b !== 2'(idxs[i])) begin
                    errors++;
                    $display("FAIL last_idx_step%0d: got %0d expected %0d", i, idx_b, idxs[i]);
                end
            end else begin
                cyc(3);
            end
        end
        kn_b = '1;
        wait_db(8'h00, n);
        cyc(3);
    endtask

    task automatic test_glitch();
        int n, len, bad;
        logic lvl;
        mon = 0;
        bad = 0;
        kn_a[0] = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (i == 10) kn_a[0] = 1'b1;
            cyc(1);
            if (db_a !== '0 || nv_a !== 1'b0 || pwm_a !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL glitch: got %0d disturbed cycles expected 0", bad);
        end
        kn_a = 4'b1110;
        wait_db(8'h01, n);
        cyc(1);
        measure(len, lvl);
        cyc(3);
        kn_a = '1;
        wait_db(8'h00, n);
        checks++;
        if (pwm_a !== 1'b1) begin
            errors++;
            $display("FAIL pre_silence: got %b expected 1", pwm_a);
        end
        cyc(1);
        checks++;
        if (pwm_a !== 1'b0) begin
            errors++;
            $display("FAIL silence: got %b expected 0", pwm_a);
        end
        cyc(1);
        checks++;
        if (nv_a !== 1'b0 || idx_a !== 2'd0) begin
            errors++;
            $display("FAIL idle_after: got valid %b idx %0d expected 0 0", nv_a, idx_a);
        end
        kn_a = 4'b1110;
        wait_db(8'h01, n);
        cyc(5);
        checks++;
        if (nv_a !== 1'b1 || pwm_a !== 1'b1) begin
            errors++;
            $display("FAIL running: got valid %b pwm %b expected 1 1", nv_a, pwm_a);
        end
        reset = 1'b1;
        cyc(1);
        checks++;
        if ({pwm_a, nv_a, idx_a, db_a} !== '0) begin
            errors++;
            $display("FAIL reset_mid: got %b expected 0", {pwm_a, nv_a, idx_a, db_a});
        end
        reset = 1'b0;
        kn_a = '1;
        cyc(25);
    endtask

    task automatic test_wide();
        int n, len, e;
        logic lvl;
        mon = 2;
        for (int k = 0; k < 8; k++) begin
            exp_q.push_back(k + 2);
            exp_q.push_back(k + 2);
            kn_c = ~(8'b1 << k);
            wait_db(8'(1 << k), n);
            cyc(1);
            measure(len, lvl);
            for (int p = 0; p < 2; p++) begin
                measure(len, lvl);
                e = exp_q.pop_front();
                checks++;
                if (len !== e || lvl !== (p == 0)) begin
                    errors++;
                    $display("FAIL wide_k%0d_%0d: got len %0d lvl %b expected len %0d lvl %b", k, p, len, lvl, e, p == 0);
                end
            end
            checks++;
            if (nv_c !== 1'b1 || idx_c !== 3'(k)) begin
                errors++;
                $display("FAIL wide_idx_k%0d: got valid %b idx %0d expected 1 %0d", k, nv_c, idx_c, k);
            end
            kn_c = '1;
            wait_db(8'h00, n);
            cyc(3);
        end
    endtask

    initial begin
        test_reset();
        test_single_keys();
        test_priority();
        test_last_pressed();
        test_glitch();
        test_wide();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
